ysyx_220066_div_seq: RTL and testbench
======================================

YSYX_220066_DIV_SEQ -- requirements
Module: ysyx_220066_Div_seq

Interface
REQ-001 SHALL have parameter: XLEN, 64, datapath width; W-mode width is XLEN/2.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port: src1  input  XLEN  dividend.
REQ-007 SHALL have port: src2  input  XLEN  divisor.
REQ-008 SHALL have port: ALUctr  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have port: is_w  input  1  32-bit (W) variant.
REQ-010 SHALL have port: flush  input  1  abort current operation.
REQ-011 SHALL have port: out_valid  output  1  result available.
REQ-012 SHALL have port: out_ready  input  1  consumer takes result.
REQ-013 SHALL have port: result  output  XLEN  quotient or remainder.
REQ-014 SHALL have port: error  output  1  divisor zero (informational; result still ISA-defined).
REQ-015 SHALL have port: busy  output  1  state != IDLE, for pipeline stall.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; special cases IDLE -> DONE directly.
REQ-017 SHALL drive in_ready=1 only in IDLE; request accepted when in_valid & in_ready & !flush.
REQ-018 SHALL latch src1, src2, ALUctr, is_w at acceptance; later input changes ignored.
REQ-019 SHALL in W mode use only src[31:0], signed ops sign-extending, unsigned ops zero-extending the 32-bit operands.
REQ-020 SHALL convert signed operands to magnitudes at acceptance and record quotient sign (sign1^sign2) and remainder sign (sign1).
REQ-021 SHALL run restoring shift-subtract, one quotient bit per cycle, N=XLEN (is_w=0) or XLEN/2 (is_w=1) BUSY cycles, using down-counter loaded with N.
REQ-022 SHALL, with acceptance in cycle 0, assert out_valid from cycle N+1 (65 for 64-bit, 33 for W).
REQ-023 SHALL apply sign correction when entering DONE; quotient/remainder selected by ALUctr[1].
REQ-024 SHALL in W mode sign-extend bit 31 of the 32-bit result to XLEN, for all four ops.
REQ-025 SHALL treat divisor zero as special: quotient all ones, remainder = dividend (W: sign-extended src1[31:0]); error=1; out_valid in cycle 1.
REQ-026 SHALL treat signed overflow (dividend most-negative of its width, divisor -1, DIV/REM only) as special: quotient = dividend, remainder 0; error=0; out_valid in cycle 1.
REQ-027 SHALL hold result and error stable while out_valid=1 and out_ready=0.
REQ-028 SHALL return to IDLE on out_valid & out_ready; no new acceptance in that same cycle.
REQ-029 SHALL on flush in any state go to IDLE next cycle, drop out_valid, discard result; flush beats out_ready.
REQ-030 SHALL ignore requests with ALUctr[2]=0 (in_ready still 1, state unchanged).
REQ-031 SHALL drive error=0 whenever out_valid=0.

Reset
REQ-032 SHALL on rst, immediately and regardless of clk, enter IDLE and clear counter and operand registers.
REQ-033 SHALL drive during/after reset: out_valid=0, result=0, error=0, busy=0, in_ready=1.
REQ-034 SHALL on rst mid-BUSY or mid-DONE discard the operation with no out_valid pulse.

Verification
REQ-035 SHALL cover: DIV src1=0xFFFFFFFFFFFFFFF9, src2=2 -> result 0xFFFFFFFFFFFFFFFD, error=0, out_valid at cycle 65; REM -> 0xFFFFFFFFFFFFFFFF.
REQ-036 SHALL cover: REMUW src1=0x000000010000000A, src2=3, is_w=1 -> result 1 at cycle 33; DIVW src1=0xFFFFFFF0, src2=4 -> 0xFFFFFFFFFFFFFFFC.
REQ-037 SHALL cover: DIVU src2=0 -> 0xFFFFFFFFFFFFFFFF, error=1, cycle 1; REMW src1=0x80000005, src2=0 -> 0xFFFFFFFF80000005, error=1.
REQ-038 SHALL cover: DIV src1=0x8000000000000000, src2=-1 -> 0x8000000000000000; REM -> 0; DIVW src1=0x80000000, src2=-1 -> 0xFFFFFFFF80000000; all error=0.
REQ-039 SHALL cover: flush at cycle 10 of BUSY -> no out_valid, in_ready=1 cycle 11; next DIVU 100/7 -> 14 at cycle 65 after its acceptance.
REQ-040 SHALL cover: out_ready low 3 cycles after out_valid -> result stable, busy=1; rst mid-BUSY -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/ysyx_220066_div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU (+W forms): XLEN or XLEN/2 BUSY cycles, 1 cycle for div-by-zero/overflow.
// in_ready only in IDLE; result held in DONE until out_ready; flush aborts from any state.
module ysyx_220066_div_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      ALUctr,
    input  logic            is_w,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            error,
    output logic            busy
);
    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, res_q, res_d;
    logic            rsel_q, rsel_d, w_q, w_d, qneg_q, qneg_d, rneg_q, rneg_d, err_q, err_d;

    logic            sgn_op, neg1, neg2, div_zero, ovf, accept;
    logic [XLEN-1:0] op1, op2, mag1, mag2, dvd_sx, min_val;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] rem_step, quo_step, qv, rv, pick, fin;

    // Operand conditioning at acceptance: width-extend, then magnitudes and result signs.
    always_comb begin
        sgn_op = ~ALUctr[0];
        op1    = src1;
        op2    = src2;
        if (is_w) begin
            op1 = sgn_op ? {{HW{src1[HW-1]}}, src1[HW-1:0]} : {{HW{1'b0}}, src1[HW-1:0]};
            op2 = sgn_op ? {{HW{src2[HW-1]}}, src2[HW-1:0]} : {{HW{1'b0}}, src2[HW-1:0]};
        end
        dvd_sx   = is_w ? {{HW{src1[HW-1]}}, src1[HW-1:0]} : src1;
        min_val  = is_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        neg1     = sgn_op & op1[XLEN-1];
        neg2     = sgn_op & op2[XLEN-1];
        mag1     = neg1 ? -op1 : op1;
        mag2     = neg2 ? -op2 : op2;
        div_zero = (op2 == '0);
        ovf      = sgn_op & (op1 == min_val) & (op2 == '1);
        accept   = in_valid & in_ready & ~flush & ALUctr[2];
    end

    // One restoring step, plus the sign-corrected result used on the final step.
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, div_q};
        rem_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};
        qv       = qneg_q ? -quo_step : quo_step;
        rv       = rneg_q ? -rem_step : rem_step;
        pick     = rsel_q ? rv : qv;
        fin      = w_q ? {{HW{pick[HW-1]}}, pick[HW-1:0]} : pick;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        res_d   = res_q;
        rsel_d  = rsel_q;
        w_d     = w_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsel_d = ALUctr[1];
                    w_d    = is_w;
                    qneg_d = neg1 ^ neg2;
                    rneg_d = neg1;
                    div_d  = mag2;
                    rem_d  = '0;
                    // W dividend sits in the upper half so its MSB is shifted out first.
                    quo_d  = is_w ? {mag1[HW-1:0], {HW{1'b0}}} : mag1;
                    cnt_d  = is_w ? CW'(HW) : CW'(XLEN);
                    err_d  = 1'b0;
                    if (div_zero) begin
                        state_d = DONE;
                        res_d   = ALUctr[1] ? dvd_sx : '1;
                        err_d   = 1'b1;
                    end else if (ovf) begin
                        state_d = DONE;
                        res_d   = ALUctr[1] ? '0 : dvd_sx;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = fin;
                end
                if (flush) state_d = IDLE;
            end
            DONE: begin
                if (flush || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        result    = out_valid ? res_q : '0;
        error     = out_valid & err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            res_q   <= '0;
            rsel_q  <= 1'b0;
            w_q     <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            res_q   <= res_d;
            rsel_q  <= rsel_d;
            w_q     <= w_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_ysyx_220066_div_seq.sv
// Directed and random checks of the sequential divider against an arithmetic reference model.
module tb_ysyx_220066_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] src1 = '0, src2 = '0;
    logic [2:0]  ALUctr = '0;
    logic        is_w = 1'b0, flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] result;
    logic        error, busy;

    int total = 0;
    int bad   = 0;

    ysyx_220066_div_seq #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .ALUctr(ALUctr), .is_w(is_w), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ov"}, 64'(out_valid), 64'd0);
        chk({tag, "_res"}, result, 64'd0);
        chk({tag, "_err"}, 64'(error), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    // Reference: RISC-V M semantics from plain arithmetic.
    function automatic void ref_div(input logic [2:0] op, input logic w, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] r,
                                    output logic e, output int lat);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub;
        logic sgn, ovf;
        sgn = !op[0];
        if (w) begin
            sa = {{32{a[31]}}, a[31:0]}; sb = {{32{b[31]}}, b[31:0]};
            ua = {32'd0, a[31:0]};       ub = {32'd0, b[31:0]};
            ovf = sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
        end else begin
            sa = a; sb = b; ua = a; ub = b;
            ovf = sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
        end
        e = 1'b0;
        lat = 1;
        if (ub == 64'd0) begin
            r = op[1] ? sa : 64'hFFFF_FFFF_FFFF_FFFF;
            e = 1'b1;
        end else if (ovf) begin
            r = op[1] ? 64'd0 : sa;
        end else begin
            lat = w ? 33 : 65;
            case (op[1:0])
                2'b00:   r = sa / sb;
                2'b01:   r = ua / ub;
                2'b10:   r = sa % sb;
                default: r = ua % ub;
            endcase
        end
        if (w) r = {{32{r[31]}}, r[31:0]};
    endfunction

    task automatic do_op(input string tag, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic ee, input int lat, input int hold);
        int k;
        logic errlow;
        chk({tag, "_inrdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; ALUctr = op; is_w = w; src1 = a; src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        ALUctr = {1'b1, 2'($urandom)}; is_w = 1'($urandom);
        k = 1;
        errlow = 1'b1;
        while (!out_valid && k < 200) begin
            if (error !== 1'b0) errlow = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(lat));
        chk({tag, "_errlow"}, 64'(errlow), 64'd1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_err"}, 64'(error), 64'(ee));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_ov"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_res"}, result, er);
            chk({tag, "_hold_err"}, 64'(error), 64'(ee));
            chk({tag, "_hold_busy"}, 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ack_ov"}, 64'(out_valid), 64'd0);
        chk({tag, "_ack_rdy"}, 64'(in_ready), 64'd1);
    endtask

    task automatic rand_op(input string tag, input logic [2:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic e;
        int lat;
        ref_div(op, w, a, b, r, e, lat);
        do_op(tag, op, w, a, b, r, e, lat, 0);
    endtask

    task automatic no_ov_for(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0] op;
        logic [63:0] a, b;
        logic w;
        #2;
        chk_reset_outs("rst_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        #10;
        chk_reset_outs("rst_rel");

        do_op("div_neg",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65, 0);
        do_op("rem_neg",  3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65, 0);
        do_op("remuw",    3'b111, 1'b1, 64'h0000_0001_0000_000A, 64'd3, 64'd1, 1'b0, 33, 0);
        do_op("divw",     3'b100, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 33, 0);
        do_op("divu_z",   3'b101, 1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 0);
        do_op("remw_z",   3'b110, 1'b1, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1'b1, 1, 0);
        do_op("div_ovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1, 0);
        do_op("rem_ovf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1, 0);
        do_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, 0);
        do_op("stall",    3'b101, 1'b0, 64'd1000, 64'd9, 64'd111, 1'b0, 65, 3);

        // A request whose ALUctr[2] is clear must be ignored.
        in_valid = 1'b1; ALUctr = 3'b001; src1 = 64'd50; src2 = 64'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ignore_busy", 64'(busy), 64'd0);
        chk("ignore_rdy", 64'(in_ready), 64'd1);

        // Flush in the tenth BUSY cycle.
        in_valid = 1'b1; ALUctr = 3'b101; is_w = 1'b0; src1 = 64'd999; src2 = 64'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_rdy", 64'(in_ready), 64'd1);
        chk("flush_ov", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        no_ov_for("flush_no_ov", 70);
        do_op("divu_after", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 65, 0);

        // Flush beats out_ready in DONE.
        in_valid = 1'b1; ALUctr = 3'b101; is_w = 1'b0; src1 = 64'd7; src2 = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fdone_ov", 64'(out_valid), 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("fdone_ov_after", 64'(out_valid), 64'd0);
        chk("fdone_rdy", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-BUSY.
        in_valid = 1'b1; ALUctr = 3'b100; is_w = 1'b0; src1 = 64'd5000; src2 = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("rstb_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_busy");
        #2 rst = 1'b0;
        no_ov_for("rst_busy_no_ov", 70);

        // Asynchronous reset mid-DONE.
        in_valid = 1'b1; ALUctr = 3'b110; is_w = 1'b0; src1 = 64'd77; src2 = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rstd_pre_ov", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_done");
        #2 rst = 1'b0;
        no_ov_for("rst_done_no_ov", 5);

        for (int n = 0; n < 40; n++) begin
            op = {1'b1, 2'($urandom)};
            w  = 1'($urandom);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 64'($urandom_range(1, 20));
                1: b = 64'd0;
                2: begin
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                    a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
                end
                3: a = 64'($urandom_range(0, 1000));
                4: b = -64'($urandom_range(1, 1000));
                default: ;
            endcase
            rand_op("rand", op, w, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
